// File: rtl/distribute_1x2_sched.sv
// Command scheduler for one distribute_1x2_comb node: queues {cmd, len}
// entries and issues len+1 beats per entry, each gated on every selected
// downstream branch being ready so a multicast beat is never half-delivered.
module distribute_1x2_sched #(
  parameter int unsigned COMMAND_WIDTH = 2,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned CFG_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cfg_valid,
  output logic                     o_cfg_ready,
  input  logic [COMMAND_WIDTH-1:0] i_cfg_cmd,
  input  logic [LEN_WIDTH-1:0]     i_cfg_len,
  input  logic                     i_data_valid,
  output logic                     o_data_ready,
  input  logic                     i_ready_high,
  input  logic                     i_ready_low,
  output logic                     o_en,
  output logic [COMMAND_WIDTH-1:0] o_cmd,
  output logic                     o_valid,
  output logic                     o_done,
  output logic                     o_busy
);

  localparam int unsigned PTR_W = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [COMMAND_WIDTH-1:0] cmd;
    logic [LEN_WIDTH-1:0]     len;
  } cfg_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                   state;
  logic [COMMAND_WIDTH-1:0] cur_cmd;
  logic [LEN_WIDTH-1:0]     cnt;

  cfg_entry_t               mem [CFG_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;

  logic                     empty;
  logic                     full;
  logic                     push;
  logic                     push_accept;
  logic                     pop;
  logic                     branch_ok;
  logic                     fire;
  logic                     last_beat;
  cfg_entry_t               head;

  // FIFO status, handshake qualification and node-facing outputs
  always_comb begin
    empty        = (count == '0);
    full         = (count == CNT_W'(CFG_DEPTH));
    head         = mem[rd_ptr];
    push_accept  = i_cfg_valid & ~full;
    // Null commands are acknowledged but never stored
    push         = push_accept & (|i_cfg_cmd);
    branch_ok    = (~cur_cmd[1] | i_ready_high) & (~cur_cmd[0] | i_ready_low);

    o_en         = 1'b0;
    o_cmd        = '0;
    o_data_ready = 1'b0;
    o_valid      = 1'b0;
    if (state == ISSUE) begin
      o_en         = 1'b1;
      o_cmd        = cur_cmd;
      o_data_ready = branch_ok;
      o_valid      = i_data_valid & branch_ok;
    end

    fire        = o_valid;
    last_beat   = fire & (cnt == '0);
    pop         = ~empty & ((state == IDLE) | last_beat);
    o_cfg_ready = ~full;
    o_busy      = (state == ISSUE) | ~empty;
  end

  // Entry storage; contents need no reset, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cfg_entry_t'({i_cfg_cmd, i_cfg_len});
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM: load entries, count beats, pulse done after the last beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_cmd <= '0;
      cnt     <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= last_beat;
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_cmd <= head.cmd;
            cnt     <= head.len;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire) begin
            if (cnt != '0) begin
              cnt <= cnt - LEN_WIDTH'(1);
            end else if (!empty) begin
              // Zero-bubble handoff to the next queued entry
              cur_cmd <= head.cmd;
              cnt     <= head.len;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_distribute_1x2_sched.sv
// Bench for distribute_1x2_sched: directed scenarios followed by random
// traffic, all compared every cycle against an entry-queue reference model.
module tb_distribute_1x2_sched;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_cfg_valid;
  logic       o_cfg_ready;
  logic [1:0] i_cfg_cmd;
  logic [7:0] i_cfg_len;
  logic       i_data_valid;
  logic       o_data_ready;
  logic       i_ready_high;
  logic       i_ready_low;
  logic       o_en;
  logic [1:0] o_cmd;
  logic       o_valid;
  logic       o_done;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  distribute_1x2_sched #(
    .COMMAND_WIDTH(2),
    .LEN_WIDTH(8),
    .CFG_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready),
    .i_cfg_cmd(i_cfg_cmd),
    .i_cfg_len(i_cfg_len),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .i_ready_high(i_ready_high),
    .i_ready_low(i_ready_low),
    .o_en(o_en),
    .o_cmd(o_cmd),
    .o_valid(o_valid),
    .o_done(o_done),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending entries, the active entry and its remaining beats
  typedef struct {
    logic [1:0] cmd;
    int         len;
  } ent_t;

  ent_t       q[$];
  bit         m_active;
  logic [1:0] m_cmd;
  int         m_left;
  bit         m_done;

  // Observed activity tallies for the directed scenarios
  int  n_done;
  int  n_beats;
  bit  seen_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_cmd    = 2'b00;
    m_left   = 0;
    m_done   = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic cycle();
    bit   e_ok;
    bit   e_valid;
    bit   e_ready;
    ent_t h;
    @(negedge clk);
    e_ok    = m_active && (!m_cmd[1] || i_ready_high) && (!m_cmd[0] || i_ready_low);
    e_valid = e_ok && i_data_valid;
    e_ready = (q.size() < DEPTH);
    chk("cfg_ready",  32'(o_cfg_ready),  32'(e_ready));
    chk("data_ready", 32'(o_data_ready), 32'(e_ok));
    chk("en",         32'(o_en),         32'(m_active));
    chk("cmd",        32'(o_cmd),        32'(m_active ? m_cmd : 2'b00));
    chk("valid",      32'(o_valid),      32'(e_valid));
    chk("done",       32'(o_done),       32'(m_done));
    chk("busy",       32'(o_busy),       32'(m_active || q.size() > 0));
    n_done     += int'(o_done);
    n_beats    += int'(o_valid);
    seen_ready  = o_cfg_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_done = e_valid && (m_left == 1);
      if (!m_active) begin
        if (q.size() > 0) begin
          h = q.pop_front();
          m_active = 1'b1; m_cmd = h.cmd; m_left = h.len + 1;
        end
      end else if (e_valid) begin
        m_left--;
        if (m_left == 0) begin
          if (q.size() > 0) begin
            h = q.pop_front();
            m_cmd = h.cmd; m_left = h.len + 1;
          end else begin
            m_active = 1'b0;
          end
        end
      end
      if (i_cfg_valid && e_ready && i_cfg_cmd != 2'b00) begin
        h.cmd = i_cfg_cmd; h.len = int'(i_cfg_len);
        q.push_back(h);
      end
    end
    #1;
  endtask

  task automatic push1(input logic [1:0] cmd, input logic [7:0] len);
    i_cfg_valid = 1'b1; i_cfg_cmd = cmd; i_cfg_len = len;
    cycle();
    i_cfg_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_tally();
    n_done = 0; n_beats = 0;
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; i_cfg_valid = 1'b0; i_cfg_cmd = 2'b00; i_cfg_len = 8'd0;
    i_data_valid = 1'b1; i_ready_high = 1'b1; i_ready_low = 1'b1;
    model_reset();
    clear_tally();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic burst
    clear_tally();
    push1(2'b01, 8'd3);
    run(8);
    chk("basic_beats", 32'(n_beats), 32'd4);
    chk("basic_done",  32'(n_done),  32'd1);

    // Duplicate with low branch stalled for two issue cycles
    clear_tally();
    push1(2'b11, 8'd1);
    i_ready_low = 1'b0;
    run(3);
    i_ready_low = 1'b1;
    run(5);
    chk("dup_beats", 32'(n_beats), 32'd2);
    chk("dup_done",  32'(n_done),  32'd1);

    // High-ready toggling must not stall a low-only entry
    clear_tally();
    push1(2'b01, 8'd3);
    for (int i = 0; i < 6; i++) begin
      i_ready_high = ~i_ready_high;
      cycle();
    end
    i_ready_high = 1'b1;
    chk("lowonly_done", 32'(n_done), 32'd1);
    run(2);

    // Back-to-back entries
    clear_tally();
    push1(2'b10, 8'd0);
    push1(2'b01, 8'd1);
    push1(2'b11, 8'd0);
    run(8);
    chk("b2b_beats", 32'(n_beats), 32'd4);
    chk("b2b_done",  32'(n_done),  32'd3);

    // FIFO full: downstream stalled, six entries offered, readies released later
    clear_tally();
    i_ready_high = 1'b0; i_ready_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      i_cfg_valid = 1'b1; i_cfg_cmd = 2'(k % 3 + 1); i_cfg_len = 8'(k % 2);
      do begin
        cycle();
        waited++;
        if (waited > 3) begin
          i_ready_high = 1'b1; i_ready_low = 1'b1;
        end
      end while (!seen_ready && waited < 40);
      if (!seen_ready) chk("full_accept_timeout", 32'd0, 32'd1);
    end
    i_cfg_valid = 1'b0;
    i_ready_high = 1'b1; i_ready_low = 1'b1;
    run(16);
    chk("full_done", 32'(n_done), 32'd6);

    // Null command discarded
    clear_tally();
    push1(2'b00, 8'd5);
    push1(2'b10, 8'd0);
    run(6);
    chk("null_beats", 32'(n_beats), 32'd1);
    chk("null_done",  32'(n_done),  32'd1);

    // Reset mid-burst
    clear_tally();
    push1(2'b11, 8'd7);
    waited = 0;
    while (n_beats < 3 && waited < 20) begin
      cycle();
      waited++;
    end
    chk("mid_beats_before_reset", 32'(n_beats), 32'd3);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(4);
    chk("mid_no_done", 32'(n_done), 32'd0);
    clear_tally();
    push1(2'b01, 8'd0);
    run(5);
    chk("post_reset_done", 32'(n_done), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      i_cfg_valid  = ($urandom_range(0, 2) == 0);
      i_cfg_cmd    = 2'($urandom_range(0, 3));
      i_cfg_len    = 8'($urandom_range(0, 3));
      i_data_valid = ($urandom_range(0, 3) != 0);
      i_ready_high = ($urandom_range(0, 3) != 0);
      i_ready_low  = ($urandom_range(0, 3) != 0);
      rst_n        = (i != 300);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
